// File: rtl/cve2_pkg.sv
// Shared types and constants for the OBI-to-SRAM bridge.
package cve2_pkg;

  localparam int unsigned MaxMemLatency = 4;
  localparam int unsigned BusWidth      = 32;
  localparam int unsigned BeWidth       = BusWidth / 8;

  // One slot of the fixed-latency response pipe.
  typedef struct packed {
    logic valid;
    logic is_read;
    logic err;
  } bridge_resp_t;

endpackage

// File: rtl/cve2_obi_mem_bridge_if.sv
// Core-side request/response bus (req/gnt/rvalid) of the memory bridge.
interface cve2_obi_mem_bridge_if;
  import cve2_pkg::*;

  logic                req;
  logic                gnt;
  logic                we;
  logic [BeWidth-1:0]  be;
  logic [BusWidth-1:0] addr;
  logic [BusWidth-1:0] wdata;
  logic                rvalid;
  logic [BusWidth-1:0] rdata;
  logic                err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/cve2_obi_resp_pipe.sv
// Fixed-depth shift register carrying response descriptors from grant to rvalid.
module cve2_obi_resp_pipe
  import cve2_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  bridge_resp_t in_i,
  output bridge_resp_t out_o
);

  bridge_resp_t stage_q [Depth];

  // Shift every cycle; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/cve2_obi_mem_bridge.sv
// Slave bridge from the core req/gnt/rvalid bus to a single-port synchronous SRAM.
// Optional address range check: define CVE2_BRIDGE_RANGE_CHK_EN.
module cve2_obi_mem_bridge
  import cve2_pkg::*;
#(
  parameter int unsigned MemLatency     = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 14,
  parameter logic [31:0] BaseAddr       = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cve2_obi_mem_bridge_if.slave  bus,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [BeWidth-1:0]    mem_be_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [BusWidth-1:0]   mem_wdata_o,
  input  logic [BusWidth-1:0]   mem_rdata_i
);

  localparam int unsigned PipeDepth = (MemLatency > MaxMemLatency) ? MaxMemLatency :
                                      (MemLatency < 1)             ? 1 : MemLatency;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

  logic [CntWidth-1:0] outstanding_q;
  logic [BusWidth-1:0] addr_off;
  logic                legal;
  logic                gnt;
  logic                issue;
  logic                retire;
  bridge_resp_t        resp_in;
  bridge_resp_t        resp_out;
  logic                unused_addr_bits;

  assign addr_off = bus.addr - BaseAddr;

`ifdef CVE2_BRIDGE_RANGE_CHK_EN
  assign legal = (addr_off[BusWidth-1:AddrWidth+2] == '0);
`else
  // Upper offset bits ignored: the window aliases across the address space.
  assign legal = 1'b1;
`endif

  assign unused_addr_bits = ^{addr_off[BusWidth-1:AddrWidth+2], addr_off[1:0]};

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign retire = resp_out.valid;
  assign gnt    = bus.req & ((outstanding_q < CntWidth'(MaxOutstanding)) | retire);
  assign issue  = gnt & legal;

  assign bus.gnt     = gnt;
  assign mem_req_o   = issue;
  assign mem_we_o    = issue & bus.we;
  assign mem_be_o    = issue ? bus.be : '0;
  assign mem_addr_o  = addr_off[AddrWidth+1:2];
  assign mem_wdata_o = bus.wdata;

  // Track granted-but-unanswered transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (gnt && !retire) begin
      outstanding_q <= outstanding_q + CntWidth'(1);
    end else if (!gnt && retire) begin
      outstanding_q <= outstanding_q - CntWidth'(1);
    end
  end

  assign resp_in = '{valid: gnt, is_read: ~bus.we, err: ~legal};

  cve2_obi_resp_pipe #(
    .Depth (PipeDepth)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (resp_in),
    .out_o  (resp_out)
  );

  assign bus.rvalid = resp_out.valid;
  assign bus.err    = resp_out.valid & resp_out.err;
  assign bus.rdata  = (resp_out.valid & resp_out.is_read & ~resp_out.err) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_cve2_obi_mem_bridge.sv
// Directed + random bench for cve2_obi_mem_bridge: three instances
// (latency 1/max 2, latency 3/max 2, latency 2/max 3) behind SRAM models.
module tb_cve2_obi_mem_bridge;

  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 2;
  endfunction

  function automatic int unsigned max_of(input int g);
    return (g == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] init_val(input int k, input int i);
    if (k == 0 && i == 16) return 32'hDEAD_BEEF;
    return {8'hA5, 8'(k), 8'h00, 8'(i)};
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic [2:0]  gnt_w, rvalid_w, err_w, mreq_w, mwe_w;
  logic [31:0] rdata_w [3];
  logic [13:0] maddr_w [3];
  logic [3:0]  mbe_w [3];
  logic [31:0] mwdata_w [3];
  logic [31:0] mrdata_w [3];

  logic [31:0] sram [3][64];
  logic [31:0] rdp [3][4];
  bit          sram_init;

  logic [31:0] ref_mem [3][64];
  exp_t        q[$];
  int          outc [3];
  int          resp_cnt [3];
  int          cyc;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cve2_obi_mem_bridge_if bus ();

    assign bus.req   = req && (sel == 2'(g));
    assign bus.we    = we;
    assign bus.be    = be;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;

    cve2_obi_mem_bridge #(
      .MemLatency     (lat_of(g)),
      .MaxOutstanding (max_of(g)),
      .AddrWidth      (14),
      .BaseAddr       (32'h0)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .mem_req_o   (mreq_w[g]),
      .mem_we_o    (mwe_w[g]),
      .mem_be_o    (mbe_w[g]),
      .mem_addr_o  (maddr_w[g]),
      .mem_wdata_o (mwdata_w[g]),
      .mem_rdata_i (mrdata_w[g])
    );

    assign gnt_w[g]    = bus.gnt;
    assign rvalid_w[g] = bus.rvalid;
    assign err_w[g]    = bus.err;
    assign rdata_w[g]  = bus.rdata;
    assign mrdata_w[g] = rdp[g][lat_of(g)-1];
  end

  // SRAM models: byte-masked writes, reads delayed through a latency pipe.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 64; i++)
          sram[k][i] <= init_val(k, i);
      sram_init <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (mreq_w[k]) begin
          if (mwe_w[k]) begin
            for (int b = 0; b < 4; b++)
              if (mbe_w[k][b]) sram[k][maddr_w[k][5:0]][8*b +: 8] <= mwdata_w[k][8*b +: 8];
          end else begin
            rdp[k][0] <= sram[k][maddr_w[k][5:0]];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++)
      for (int d = 1; d < 4; d++)
        rdp[k][d] <= rdp[k][d-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on rvalid, push on grant, track outstanding per instance.
  task automatic monitor();
    exp_t e;
    int   widx;
    logic legal;
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 3; k++) outc[k] = 0;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (rvalid_w[k]) begin
        resp_cnt[k]++;
        if (q.size() == 0) begin
          chk("spurious_rvalid", 32'(rvalid_w[k]), 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp_inst", 32'(k), 32'(e.inst));
          chk("resp_rdata", rdata_w[k], e.rdata);
          chk("resp_err", 32'(err_w[k]), 32'(e.err));
          chk("resp_latency", 32'(cyc - e.gcyc), 32'(lat_of(k)));
        end
      end
      if (gnt_w[k]) begin
        widx = int'(addr[7:2]);
`ifdef CVE2_BRIDGE_RANGE_CHK_EN
        legal = (addr[31:16] == 16'h0);
`else
        legal = 1'b1;
`endif
        e.inst  = k;
        e.err   = ~legal;
        e.rdata = (!we && legal) ? ref_mem[k][widx] : 32'h0;
        e.gcyc  = cyc;
        q.push_back(e);
        if (we && legal)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[k][widx][8*b +: 8] = wdata[8*b +: 8];
      end
      outc[k] = outc[k] + int'(gnt_w[k]) - int'(rvalid_w[k]);
      chk("outstanding_le_max", 32'(outc[k] <= int'(max_of(k))), 32'd1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic r, input logic w,
                       input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    sel = s; req = r; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [5:0] pat;
  int         grants;

  initial begin
    checks = 0; errors = 0; cyc = 0; grants = 0;
    for (int k = 0; k < 3; k++) begin
      outc[k] = 0; resp_cnt[k] = 0;
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_val(k, i);
    end
    rst_n = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick();

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt", 32'(gnt_w[k]), 32'd0);
      chk("rst_rvalid", 32'(rvalid_w[k]), 32'd0);
      chk("rst_rdata", rdata_w[k], 32'd0);
      chk("rst_err", 32'(err_w[k]), 32'd0);
      chk("rst_mem_req", 32'(mreq_w[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Single read, latency 1
    drive(2'd0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    #1;
    chk("rd_gnt", 32'(gnt_w[0]), 32'd1);
    chk("rd_mem_req", 32'(mreq_w[0]), 32'd1);
    chk("rd_mem_addr", 32'(maddr_w[0]), 32'h10);
    chk("rd_mem_we", 32'(mwe_w[0]), 32'd0);
    tick();
    req = 1'b0;
    #1;
    chk("rd_rvalid", 32'(rvalid_w[0]), 32'd1);
    chk("rd_rdata", rdata_w[0], 32'hDEAD_BEEF);
    tick();

    // Write with partial byte enables
    drive(2'd0, 1'b1, 1'b1, 4'b0011, 32'h44, 32'h1234_5678);
    #1;
    chk("wr_gnt", 32'(gnt_w[0]), 32'd1);
    chk("wr_mem_we", 32'(mwe_w[0]), 32'd1);
    chk("wr_mem_be", 32'(mbe_w[0]), 32'b0011);
    chk("wr_mem_wdata", mwdata_w[0], 32'h1234_5678);
    tick();
    req = 1'b0;
    #1;
    chk("wr_rvalid", 32'(rvalid_w[0]), 32'd1);
    chk("wr_rdata", rdata_w[0], 32'd0);
    chk("wr_err", 32'(err_w[0]), 32'd0);
    tick();

    // Read back the merged word
    drive(2'd0, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0);
    tick();
    req = 1'b0;
    #1;
    chk("rb_rdata", rdata_w[0], 32'hA500_5678);
    tick();

    // Address outside the 64 KiB window
    drive(2'd0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    #1;
    chk("oor_gnt", 32'(gnt_w[0]), 32'd1);
`ifdef CVE2_BRIDGE_RANGE_CHK_EN
    chk("oor_mem_req", 32'(mreq_w[0]), 32'd0);
`else
    chk("oor_mem_req", 32'(mreq_w[0]), 32'd1);
    chk("oor_alias_addr", 32'(maddr_w[0]), 32'd0);
`endif
    tick();
    req = 1'b0;
    #1;
    chk("oor_rvalid", 32'(rvalid_w[0]), 32'd1);
`ifdef CVE2_BRIDGE_RANGE_CHK_EN
    chk("oor_err", 32'(err_w[0]), 32'd1);
    chk("oor_rdata", rdata_w[0], 32'd0);
`else
    chk("oor_err", 32'(err_w[0]), 32'd0);
    chk("oor_rdata", rdata_w[0], 32'hA500_0000);
`endif
    tick();
    drain();

    // Latency 3, max 2: held request throttled by the outstanding limit
    pat = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, 1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
      #1;
      chk("full_gnt_pattern", 32'(gnt_w[1]), 32'(pat[i]));
      tick();
    end
    req = 1'b0;
    drain();

    // Reset with two reads in flight
    drive(2'd1, 1'b1, 1'b0, 4'hF, 32'h08, 32'h0);
    #1;
    chk("rstmid_gnt0", 32'(gnt_w[1]), 32'd1);
    tick();
    addr = 32'h0C;
    #1;
    chk("rstmid_gnt1", 32'(gnt_w[1]), 32'd1);
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rvalid_in_reset", 32'(rvalid_w[1]), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_rvalid", 32'(rvalid_w[1]), 32'd0);
    end
    drive(2'd1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    chk("rstmid_regrant", 32'(gnt_w[1]), 32'd1);
    tick();
    req = 1'b0;
    drain();

    // Latency 2, max 3: random traffic, one grant per cycle sustained
    for (int i = 0; i < 100; i++) begin
      drive(2'd2, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 32'($urandom_range(0, 63)) << 2, $urandom());
      #1;
      chk("b2b_gnt", 32'(gnt_w[2]), 32'(req));
      if (req && gnt_w[2]) grants++;
      tick();
    end
    req = 1'b0;
    drain();
    chk("resp_count", 32'(resp_cnt[2]), 32'(grants));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
